// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word/address widths,
// the in-flight pipe stage record and the buffered {pc, instr} entry.
// Ports: none (package).
package instruction_fetch_unit_pkg;

  localparam int          WORD_BYTES = 4;
  localparam int          INSTR_W    = 32;
  localparam int          ADDR_W     = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  // One stage of the outstanding-fetch pipe.
  typedef struct packed {
    logic              vld;
    logic              epoch;
    logic [ADDR_W-1:0] pc;
  } inflight_t;

  // Entry held in the output buffer; pc in the upper half.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with registered head, single-cycle flush and occupancy count.
// Ports: clk/reset (async, active-high), push/wdata, pop/rdata, flush,
//        count, full, empty. Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, credit-limited word fetch from a fixed-latency
// big-endian memory, epoch-tagged in-flight pipe and {pc, instr} output buffer.
// Ports: clk, reset (async active-high), imem_req/imem_addr/imem_data to memory,
//        redirect/redirect_pc from branch resolution, out_valid/out_ready/out_instr/out_pc to decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  inflight_t         pipe_q [MEM_LATENCY];
  inflight_t         exit_e;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [31:0]       inflight_cnt;
  logic [31:0]       credit_used;
  logic              fifo_push, fifo_pop;
  fetch_entry_t      push_entry, head_entry;

  assign exit_e = pipe_q[MEM_LATENCY-1];

  // Only current-epoch fetches hold a credit; stale ones will be dropped on exit,
  // so counting them would needlessly stall the first fetches after a redirect.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (pipe_q[i].vld && (pipe_q[i].epoch == epoch_q)) inflight_cnt = inflight_cnt + 32'd1;
    end
  end

  assign credit_used = 32'(fifo_count) + inflight_cnt;
  // reset gates the request combinationally so it drops the moment reset rises.
  assign imem_req    = !reset && !redirect && (credit_used < 32'(FIFO_DEPTH));
  assign imem_addr   = pc_q;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q ^ redirect;
    if (redirect)      pc_d = word_align(redirect_pc);
    else if (imem_req) pc_d = pc_q + ADDR_W'(WORD_BYTES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      pipe_q[0] <= '{vld: imem_req, epoch: epoch_q, pc: pc_q};
      for (int i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The exiting stage lines up with imem_data; keep it only if it belongs to
  // the current stream. The credit check means the buffer is never full here.
  assign fifo_push  = exit_e.vld && (exit_e.epoch == epoch_q) && !fifo_full;
  assign fifo_pop   = out_valid && out_ready;
  assign push_entry = '{pc: exit_e.pc, instr: imem_data};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .flush (redirect),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : head_entry.pc;
  assign out_instr = fifo_empty ? NOP_INSTR : head_entry.instr;

endmodule
